priority_irq_controller: RTL and testbench
==========================================

Name: priority_irq_controller

Overview:
- 8-line interrupt controller: edge-detects request lines, latches them as pending, applies a mask, and picks one winner by fixed priority.
- Priority is highest index wins (line 7 highest, line 0 lowest), the same rule as the team's 8-bit priority encoder.
- Offers the winner's ID to a single consumer over a valid/ack handshake, then tracks it as in-service until end-of-interrupt (EOI). No nesting.
- Sits between peripheral request lines and the core's interrupt entry logic.

Parameters:
- NUM_IRQ, 8, number of request lines (fixed at 8 in this revision).
- ID_W, 3, width of interrupt ID; must equal log2(NUM_IRQ).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  8  raw request lines; a rising edge requests service.
- mask_wr  input  1  load strobe for the mask register.
- mask_data  input  8  new mask value; bit=1 masks that line.
- irq_valid  output  1  an unmasked pending interrupt is offered.
- irq_id  output  3  ID of the offered interrupt; meaningful only while irq_valid=1.
- irq_ack  input  1  consumer accepts the offer this cycle.
- eoi  input  1  consumer finished servicing the in-service interrupt.
- pending  output  8  pending register, for status and debug.
- in_service  output  1  an acknowledged interrupt awaits EOI.
- isr_id  output  3  ID of the in-service interrupt.

Behaviour:
- Reset values (synchronous rst):
  - irq_valid=0, irq_id=0, pending=0, in_service=0, isr_id=0.
  - Mask register=8'hFF (all masked).
  - Edge-detect register irq_q=0.
  - FSM=IDLE.
  - rst during any state aborts the current offer or service with no further side effects.
- Edge detect:
  - irq_q samples irq_in every cycle.
  - edge = irq_in & ~irq_q.
  - A line held high through reset release therefore counts as one edge on the first cycle after reset.
  - Level alone never re-requests; an edge is captured into pending regardless of mask.
- Mask:
  - mask_wr loads mask_data; the new mask is effective from the next cycle.
  - Masking a pending line hides it but does not clear it. Unmasking re-exposes it.
- Selection:
  - eligible = pending & ~mask.
  - winner = index of the highest set bit of eligible; when eligible=0 there is no winner.
- Pending update per bit i, per cycle:
  - Set if edge[i].
  - Otherwise cleared if ack_fire and irq_id==i.
  - Set wins over clear on the same bit in the same cycle, so the line stays pending.
- ack_fire = irq_ack & irq_valid. irq_ack with irq_valid=0 is ignored.
- FSM states: IDLE, OFFER, SERVICE.
  - IDLE: if eligible != 0, go to OFFER and register irq_id=winner and irq_valid=1.
  - OFFER, ack_fire: go to SERVICE. irq_valid=0, in_service=1, isr_id=irq_id, clear pending bit as above.
  - OFFER, no ack, eligible=0 (e.g. masked away): go to IDLE, irq_valid=0.
  - OFFER, no ack, eligible != 0: irq_id re-registers to the current winner, so a higher-priority arrival preempts an unacked offer.
  - SERVICE: irq_valid stays 0 and no offers are made. On eoi: in_service=0, go to IDLE. isr_id holds its last value.
- eoi outside SERVICE is ignored.
- ack_fire takes effect using the irq_id visible in that same cycle, even if mask_wr or a new edge arrives in that cycle.
- Latency:
  - Edge sampled at clock edge k sets pending visibly at cycle k+1.
  - irq_valid asserts at k+2 if the line is unmasked and the FSM is IDLE.
  - After eoi at edge m, FSM=IDLE at m+1; earliest next irq_valid is m+2.
- Edges keep accumulating into pending during OFFER and SERVICE; repeat edges on an already-pending bit collapse to one.

Test Plan:
- Reset release, mask=8'h00 written, pulse irq_in[3] -> pending=8'h08 one cycle after edge; irq_valid=1, irq_id=3 one cycle later.
- Pulse bits 2 and 6 in the same cycle, unmasked -> irq_id=6. Ack -> in_service=1, isr_id=6, pending=8'h04. eoi -> next offer irq_id=2.
- Offer irq_id=1 pending, unacked; pulse irq_in[5] -> irq_id becomes 5 without irq_valid dropping.
- Default mask 8'hFF, pulse irq_in[0] -> pending=8'h01, irq_valid stays 0. Write mask 8'hFE -> irq_valid=1, irq_id=0 two cycles after mask_wr.
- In SERVICE with isr_id=4, new edges on bits 7 and 4 -> no offer until eoi. After eoi -> irq_id=7. Ack, eoi -> irq_id=4.
- Ack of irq_id=3 in the same cycle as a new edge on irq_in[3] -> pending[3] stays 1. Assert rst mid-SERVICE -> all outputs return to reset values and mask=8'hFF.

Source files
------------

// File: rtl/priority_irq_controller.sv
// Eight-line edge-triggered interrupt controller: latches rising edges as pending,
// masks them, offers the highest-index eligible line, and tracks it until EOI.
module priority_irq_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_service,
    output logic [ID_W-1:0]    isr_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_r;
    logic [NUM_IRQ-1:0] irq_q_r;
    logic [NUM_IRQ-1:0] mask_r;
    logic [NUM_IRQ-1:0] pending_r;
    logic               irq_valid_r;
    logic [ID_W-1:0]    irq_id_r;
    logic               in_service_r;
    logic [ID_W-1:0]    isr_id_r;

    logic [NUM_IRQ-1:0] edge_s;
    logic [NUM_IRQ-1:0] eligible_s;
    logic [NUM_IRQ-1:0] clear_s;
    logic [ID_W-1:0]    winner_s;
    logic               ack_fire_s;

    // Highest set index wins; returns zero for an empty vector (caller checks emptiness).
    function automatic logic [ID_W-1:0] top_index(input logic [NUM_IRQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Edge detection, eligibility, winner selection and ack-driven clear vector.
    always_comb begin
        edge_s     = irq_in & ~irq_q_r;
        eligible_s = pending_r & ~mask_r;
        winner_s   = top_index(eligible_s);
        ack_fire_s = irq_ack & irq_valid_r;
        if (ack_fire_s) begin
            clear_s = {{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_id_r;
        end else begin
            clear_s = {NUM_IRQ{1'b0}};
        end
    end

    // Input history, mask register and pending latch; a new edge beats an ack clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q_r   <= {NUM_IRQ{1'b0}};
            mask_r    <= {NUM_IRQ{1'b1}};
            pending_r <= {NUM_IRQ{1'b0}};
        end else begin
            irq_q_r   <= irq_in;
            pending_r <= (pending_r & ~clear_s) | edge_s;
            if (mask_wr) begin
                mask_r <= mask_data;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Offer / service state machine with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            irq_valid_r  <= 1'b0;
            irq_id_r     <= {ID_W{1'b0}};
            in_service_r <= 1'b0;
            isr_id_r     <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (eligible_s != {NUM_IRQ{1'b0}}) begin
                        state_r     <= OFFER;
                        irq_valid_r <= 1'b1;
                        irq_id_r    <= winner_s;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                OFFER: begin
                    if (ack_fire_s) begin
                        state_r      <= SERVICE;
                        irq_valid_r  <= 1'b0;
                        in_service_r <= 1'b1;
                        isr_id_r     <= irq_id_r;
                    end else if (eligible_s == {NUM_IRQ{1'b0}}) begin
                        state_r     <= IDLE;
                        irq_valid_r <= 1'b0;
                    end else begin
                        // An unacked offer follows the current winner, so a
                        // higher-priority arrival preempts it.
                        irq_id_r <= winner_s;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state_r      <= IDLE;
                        in_service_r <= 1'b0;
                    end else begin
                        state_r <= SERVICE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    irq_valid_r  <= 1'b0;
                    in_service_r <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid  = irq_valid_r;
    assign irq_id     = irq_id_r;
    assign pending    = pending_r;
    assign in_service = in_service_r;
    assign isr_id     = isr_id_r;

endmodule

// File: tb/tb_priority_irq_controller.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of the controller.
module tb_priority_irq_controller;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic       eoi;
    logic [7:0] pending;
    logic       in_service;
    logic [2:0] isr_id;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_pend, m_mask, m_prev;
    bit         m_valid, m_insvc;
    int         m_id, m_isr;

    priority_irq_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .pending    (pending),
        .in_service (in_service),
        .isr_id     (isr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock: model computes next state from pre-edge state and inputs, then compare.
    task automatic cycle();
        logic [7:0] n_pend, n_mask, elig, edges;
        bit         n_valid, n_insvc, fire;
        int         n_id, n_isr, win;
        n_pend = m_pend; n_mask = m_mask; n_valid = m_valid; n_insvc = m_insvc;
        n_id = m_id; n_isr = m_isr;
        if (rst) begin
            n_pend = 8'h00; n_mask = 8'hFF; n_valid = 1'b0; n_insvc = 1'b0;
            n_id = 0; n_isr = 0;
        end else begin
            edges = irq_in & ~m_prev;
            elig  = m_pend & ~m_mask;
            win   = highest(elig);
            fire  = irq_ack && m_valid;
            if (fire) n_pend[m_id] = 1'b0;
            n_pend = n_pend | edges;
            if (m_valid) begin
                if (fire) begin
                    n_valid = 1'b0; n_insvc = 1'b1; n_isr = m_id;
                end else if (win < 0) begin
                    n_valid = 1'b0;
                end else begin
                    n_id = win;
                end
            end else if (m_insvc) begin
                if (eoi) n_insvc = 1'b0;
            end else if (win >= 0) begin
                n_valid = 1'b1; n_id = win;
            end
            if (mask_wr) n_mask = mask_data;
        end
        m_prev = rst ? 8'h00 : irq_in;
        @(posedge clk);
        #1;
        m_pend = n_pend; m_mask = n_mask; m_valid = n_valid; m_insvc = n_insvc;
        m_id = n_id; m_isr = n_isr;
        check_val("valid", 32'(irq_valid), 32'(m_valid));
        check_val("pending", 32'(pending), 32'(m_pend));
        check_val("in_service", 32'(in_service), 32'(m_insvc));
        check_val("isr_id", 32'(isr_id), 32'(m_isr));
        if (m_valid) check_val("irq_id", 32'(irq_id), 32'(m_id));
    endtask

    task automatic ack_then_eoi();
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        eoi = 1'b1; cycle(); eoi = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_in = v; cycle(); irq_in = 8'h00;
    endtask

    initial begin
        rst = 1'b1; irq_in = 8'h00; mask_wr = 1'b0; mask_data = 8'h00;
        irq_ack = 1'b0; eoi = 1'b0;
        m_pend = 8'h00; m_mask = 8'hFF; m_prev = 8'h00;
        m_valid = 1'b0; m_insvc = 1'b0; m_id = 0; m_isr = 0;
        cycle(); cycle();
        check_val("rst_irq_id", 32'(irq_id), 32'd0);
        check_val("rst_pending", 32'(pending), 32'h00);
        rst = 1'b0;

        // Single line after unmask
        mask_wr = 1'b1; mask_data = 8'h00; cycle(); mask_wr = 1'b0;
        pulse(8'h08);
        check_val("t1_pending", 32'(pending), 32'h08);
        check_val("t1_valid_early", 32'(irq_valid), 32'd0);
        cycle();
        check_val("t1_valid", 32'(irq_valid), 32'd1);
        check_val("t1_id", 32'(irq_id), 32'd3);
        ack_then_eoi();

        // Two simultaneous lines: higher index first
        pulse(8'h44);
        cycle();
        check_val("t2_id6", 32'(irq_id), 32'd6);
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        check_val("t2_insvc", 32'(in_service), 32'd1);
        check_val("t2_isr", 32'(isr_id), 32'd6);
        check_val("t2_pend", 32'(pending), 32'h04);
        eoi = 1'b1; cycle(); eoi = 1'b0;
        cycle();
        check_val("t2_id2", 32'(irq_id), 32'd2);
        ack_then_eoi();

        // Preemption of an unacked offer
        pulse(8'h02);
        cycle();
        check_val("t3_id1", 32'(irq_id), 32'd1);
        pulse(8'h20);
        cycle();
        check_val("t3_valid", 32'(irq_valid), 32'd1);
        check_val("t3_id5", 32'(irq_id), 32'd5);
        ack_then_eoi();
        cycle();
        ack_then_eoi();

        // Default mask hides the line until unmasked
        rst = 1'b1; cycle(); rst = 1'b0;
        pulse(8'h01);
        check_val("t4_pend", 32'(pending), 32'h01);
        cycle();
        check_val("t4_masked", 32'(irq_valid), 32'd0);
        mask_wr = 1'b1; mask_data = 8'hFE; cycle(); mask_wr = 1'b0;
        cycle();
        check_val("t4_valid", 32'(irq_valid), 32'd1);
        check_val("t4_id0", 32'(irq_id), 32'd0);
        ack_then_eoi();

        // No offers during service
        mask_wr = 1'b1; mask_data = 8'h00; cycle(); mask_wr = 1'b0;
        pulse(8'h10);
        cycle();
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        pulse(8'h90);
        cycle();
        check_val("t5_no_offer", 32'(irq_valid), 32'd0);
        check_val("t5_pend", 32'(pending), 32'h90);
        eoi = 1'b1; cycle(); eoi = 1'b0;
        cycle();
        check_val("t5_id7", 32'(irq_id), 32'd7);
        ack_then_eoi();
        cycle();
        check_val("t5_id4", 32'(irq_id), 32'd4);
        ack_then_eoi();

        // Ack colliding with a new edge on the same line, then reset mid-service
        pulse(8'h08);
        cycle();
        irq_ack = 1'b1; irq_in = 8'h08; cycle(); irq_ack = 1'b0; irq_in = 8'h00;
        check_val("t6_pend3", 32'(pending[3]), 32'd1);
        check_val("t6_insvc", 32'(in_service), 32'd1);
        rst = 1'b1; cycle(); rst = 1'b0;
        check_val("t6_rst_insvc", 32'(in_service), 32'd0);
        check_val("t6_rst_pend", 32'(pending), 32'h00);
        check_val("t6_rst_isr", 32'(isr_id), 32'd0);
        pulse(8'h80);
        cycle(); cycle();
        check_val("t6_mask_ff", 32'(irq_valid), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            irq_in    = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            mask_wr   = ($urandom_range(0, 15) == 0);
            mask_data = 8'($urandom) & 8'($urandom);
            irq_ack   = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
